multi_chan_prescaled_counter: RTL and testbench

- Parametrised successor to the two-output select/enable counter.
- Holds CH independent WIDTH-bit counters. Each cycle, `En` and `Slt` pick at most one channel to advance.
- Channel k advances once per 2^(k*DIV_SHIFT) selected cycles, so CH=2, DIV_SHIFT=2 gives the legacy behaviour: channel 0 every cycle, channel 1 every 4 cycles.
- Adds up/down counting, wrap or saturate mode, synchronous per-channel load, sticky overflow flags and advance pulses. Used as the general event/timer counter bank in lab designs.

---
 rtl/multi_chan_prescaled_counter.sv | 82 ++++++++
 tb/tb_multi_chan_prescaled_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_chan_prescaled_counter.sv
// Bank of CH independent WIDTH-bit up/down counters, one channel advanced per cycle
// through a per-channel power-of-two prescaler, with load, wrap/saturate and sticky overflow.
module multi_chan_prescaled_counter #(
    parameter int WIDTH     = 64,
    parameter int CH        = 4,
    parameter int SEL_W     = 2,
    parameter int DIV_SHIFT = 2,
    parameter int SAT       = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic [SEL_W-1:0]      slt_i,
    input  logic                  dir_i,
    input  logic                  ld_i,
    input  logic [SEL_W-1:0]      ld_ch_i,
    input  logic [WIDTH-1:0]      ld_val_i,
    input  logic [CH-1:0]         ovf_clr_i,
    output logic [CH*WIDTH-1:0]   count_o,
    output logic [CH-1:0]         ovf_o,
    output logic [CH-1:0]         tick_o
);

    // Sized for the slowest channel; faster channels only ever use the low bits.
    localparam int PRE_W = ((CH - 1) * DIV_SHIFT > 0) ? (CH - 1) * DIV_SHIFT : 1;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        localparam logic [PRE_W:0]   ONE_SH = (PRE_W + 1)'(1) << (k * DIV_SHIFT);
        localparam logic [PRE_W-1:0] TERM   = PRE_W'(ONE_SH - 1'b1);

        logic [PRE_W-1:0] pre_q, pre_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             ovf_q, ovf_d;
        logic             tick_q, tick_d;
        logic             load, sel, adv, at_limit, ovf_evt;
        logic [WIDTH-1:0] stepped;

        always_comb begin
            load     = ld_i && (ld_ch_i == SEL_W'(k));
            sel      = en_i && (slt_i == SEL_W'(k)) && !load;
            adv      = sel && (pre_q == TERM);
            at_limit = dir_i ? (&cnt_q) : (cnt_q == '0);
            ovf_evt  = adv && at_limit;
            stepped  = dir_i ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));

            pre_d = pre_q;
            cnt_d = cnt_q;
            if (load) begin
                cnt_d = ld_val_i;
                pre_d = '0;
            end else if (sel) begin
                pre_d = adv ? '0 : (pre_q + PRE_W'(1));
                // In saturate mode an overflowing advance still ticks but holds the value.
                if (adv && !(ovf_evt && (SAT != 0))) begin
                    cnt_d = stepped;
                end
            end

            ovf_d  = ovf_evt | (ovf_q & ~ovf_clr_i[k]);
            tick_d = adv;
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                pre_q  <= '0;
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                pre_q  <= pre_d;
                cnt_q  <= cnt_d;
                ovf_q  <= ovf_d;
                tick_q <= tick_d;
            end
        end

        assign count_o[k*WIDTH +: WIDTH] = cnt_q;
        assign ovf_o[k]                  = ovf_q;
        assign tick_o[k]                 = tick_q;
    end

endmodule

// File: tb/tb_multi_chan_prescaled_counter.sv
// Drives three counter banks (wrap, saturate, 3-channel) with shared stimulus and
// compares every output each cycle against an arithmetic reference model.
module tb_multi_chan_prescaled_counter;

    localparam int W   = 16;
    localparam int MAX = 65535;

    logic        clk = 1'b0;
    logic        rst, en, dir, ld;
    logic [1:0]  slt, ldch;
    logic [15:0] ldval;
    logic [3:0]  clr;

    logic [63:0] cnt_a, cnt_b;
    logic [47:0] cnt_c;
    logic [3:0]  ovf_a, tick_a, ovf_b, tick_b;
    logic [2:0]  ovf_c, tick_c;

    int n_assert = 0;
    int n_fail   = 0;

    int m_cnt  [3][4];
    int m_sel  [3][4];
    bit m_ovf  [3][4];
    bit m_tick [3][4];
    int nch    [3] = '{4, 4, 3};
    bit msat   [3] = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    multi_chan_prescaled_counter #(.WIDTH(W), .CH(4), .SEL_W(2), .DIV_SHIFT(2), .SAT(0)) u_wrap (
        .clk_i(clk), .reset_i(rst), .en_i(en), .slt_i(slt), .dir_i(dir), .ld_i(ld),
        .ld_ch_i(ldch), .ld_val_i(ldval), .ovf_clr_i(clr),
        .count_o(cnt_a), .ovf_o(ovf_a), .tick_o(tick_a));

    multi_chan_prescaled_counter #(.WIDTH(W), .CH(4), .SEL_W(2), .DIV_SHIFT(2), .SAT(1)) u_sat (
        .clk_i(clk), .reset_i(rst), .en_i(en), .slt_i(slt), .dir_i(dir), .ld_i(ld),
        .ld_ch_i(ldch), .ld_val_i(ldval), .ovf_clr_i(clr),
        .count_o(cnt_b), .ovf_o(ovf_b), .tick_o(tick_b));

    multi_chan_prescaled_counter #(.WIDTH(W), .CH(3), .SEL_W(2), .DIV_SHIFT(2), .SAT(0)) u_ch3 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .slt_i(slt), .dir_i(dir), .ld_i(ld),
        .ld_ch_i(ldch), .ld_val_i(ldval), .ovf_clr_i(clr[2:0]),
        .count_o(cnt_c), .ovf_o(ovf_c), .tick_o(tick_c));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dut_cnt(input int i, input int k);
        case (i)
            0:       return cnt_a[k*16 +: 16];
            1:       return cnt_b[k*16 +: 16];
            default: return cnt_c[k*16 +: 16];
        endcase
    endfunction

    function automatic logic dut_ovf(input int i, input int k);
        case (i)
            0:       return ovf_a[k];
            1:       return ovf_b[k];
            default: return ovf_c[k];
        endcase
    endfunction

    function automatic logic dut_tick(input int i, input int k);
        case (i)
            0:       return tick_a[k];
            1:       return tick_b[k];
            default: return tick_c[k];
        endcase
    endfunction

    // Channel k advances on every (4**k)-th selected cycle since reset/load.
    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < nch[i]; k++) begin
                bit load, sel, adv, evt;
                int ratio, nxt;
                if (rst) begin
                    m_cnt[i][k] = 0; m_sel[i][k] = 0; m_ovf[i][k] = 0; m_tick[i][k] = 0;
                    continue;
                end
                load  = ld && (int'(ldch) == k);
                sel   = en && (int'(slt) == k) && !load;
                adv   = 0;
                evt   = 0;
                ratio = 1 << (2 * k);
                if (load) begin
                    m_cnt[i][k] = int'(ldval);
                    m_sel[i][k] = 0;
                end else if (sel) begin
                    m_sel[i][k]++;
                    if (m_sel[i][k] == ratio) begin
                        m_sel[i][k] = 0;
                        adv = 1;
                    end
                end
                if (adv) begin
                    if (dir) begin
                        evt = (m_cnt[i][k] == MAX);
                        nxt = (m_cnt[i][k] + 1) % (MAX + 1);
                    end else begin
                        evt = (m_cnt[i][k] == 0);
                        nxt = (m_cnt[i][k] + MAX) % (MAX + 1);
                    end
                    if (!(evt && msat[i])) m_cnt[i][k] = nxt;
                end
                m_ovf[i][k]  = evt ? 1'b1 : (clr[k] ? 1'b0 : m_ovf[i][k]);
                m_tick[i][k] = adv;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < nch[i]; k++) begin
                check($sformatf("cnt[%0d][%0d]", i, k),  64'(dut_cnt(i, k)),  64'(m_cnt[i][k]));
                check($sformatf("ovf[%0d][%0d]", i, k),  64'(dut_ovf(i, k)),  64'(m_ovf[i][k]));
                check($sformatf("tick[%0d][%0d]", i, k), 64'(dut_tick(i, k)), 64'(m_tick[i][k]));
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [1:0] s, input bit d,
                        input bit l, input logic [1:0] lc, input logic [15:0] lv,
                        input logic [3:0] c);
        @(negedge clk);
        rst = r; en = e; slt = s; dir = d; ld = l; ldch = lc; ldval = lv; clr = c;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic run(input int n, input bit e, input logic [1:0] s, input bit d);
        for (int j = 0; j < n; j++) step(0, e, s, d, 0, 2'd0, 16'd0, 4'd0);
    endtask

    initial begin
        rst = 1; en = 0; slt = 0; dir = 1; ld = 0; ldch = 0; ldval = 0; clr = 0;

        // Basic prescaled counting
        step(1, 0, 0, 1, 0, 0, 0, 0);
        check("rst_cnt", cnt_a, 64'd0);
        run(3, 1, 2'd1, 1);
        check("t1_no_tick_yet", 64'(tick_a[1]), 64'd0);
        run(1, 1, 2'd1, 1);
        check("t1_tick4", 64'(tick_a[1]), 64'd1);
        run(8, 1, 2'd1, 1);
        check("t1_cnt1", 64'(cnt_a[31:16]), 64'd3);
        run(20, 1, 2'd0, 1);
        check("t1_cnt0", 64'(cnt_a[15:0]), 64'd20);
        check("t1_cnt1_hold", 64'(cnt_a[31:16]), 64'd3);

        // Prescaler retention across Slt changes
        step(1, 0, 0, 1, 0, 0, 0, 0);
        run(10, 1, 2'd2, 1);
        run(5, 1, 2'd0, 1);
        run(5, 1, 2'd2, 1);
        check("t2_cnt2_early", 64'(cnt_a[47:32]), 64'd0);
        run(1, 1, 2'd2, 1);
        check("t2_cnt2", 64'(cnt_a[47:32]), 64'd1);
        check("t2_cnt0", 64'(cnt_a[15:0]), 64'd5);

        // Wrap / saturate / clear / down-wrap
        step(0, 0, 0, 1, 1, 2'd0, 16'hFFFF, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("t3_wrap_cnt", 64'(cnt_a[15:0]), 64'd0);
        check("t3_wrap_ovf", 64'(ovf_a[0]), 64'd1);
        check("t3_sat_cnt", 64'(cnt_b[15:0]), 64'hFFFF);
        check("t3_sat_ovf", 64'(ovf_b[0]), 64'd1);
        check("t3_sat_tick", 64'(tick_b[0]), 64'd1);
        step(0, 0, 0, 1, 0, 0, 0, 4'b0001);
        check("t3_clr", 64'(ovf_a[0]), 64'd0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("t3_down_wrap", 64'(cnt_a[15:0]), 64'hFFFF);
        check("t3_down_ovf", 64'(ovf_a[0]), 64'd1);

        // Simultaneous load/advance/clear
        step(0, 1, 0, 1, 1, 2'd0, 16'd100, 0);
        check("t4_load_beats_adv", 64'(cnt_a[15:0]), 64'd100);
        check("t4_load_no_tick", 64'(tick_a[0]), 64'd0);
        step(0, 1, 0, 1, 1, 2'd3, 16'd7, 0);
        check("t4_ld_ch3", 64'(cnt_a[63:48]), 64'd7);
        check("t4_ch0_adv", 64'(cnt_a[15:0]), 64'd101);
        step(0, 0, 0, 1, 0, 0, 0, 4'b0001);
        step(0, 0, 0, 1, 1, 2'd0, 16'hFFFF, 0);
        step(0, 1, 0, 1, 0, 0, 0, 4'b0001);
        check("t4_set_wins", 64'(ovf_a[0]), 64'd1);

        // Reset clears partial prescale
        step(1, 0, 0, 1, 0, 0, 0, 0);
        run(3, 1, 2'd1, 1);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        run(3, 1, 2'd1, 1);
        check("t5_not_yet", 64'(cnt_a[31:16]), 64'd0);
        run(1, 1, 2'd1, 1);
        check("t5_cnt1", 64'(cnt_a[31:16]), 64'd1);
        check("t5_ovf", 64'(ovf_a), 64'd0);

        // Out-of-range select and disable on the 3-channel bank
        step(1, 0, 0, 1, 0, 0, 0, 0);
        run(8, 1, 2'd3, 1);
        run(8, 0, 2'd0, 1);
        check("t6_cnt", 64'(cnt_c), 64'd0);
        check("t6_tick", 64'(tick_c), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit r, e, d, l;
            logic [1:0] s, lc;
            logic [15:0] lv;
            logic [3:0] c;
            r = ($urandom_range(0, 63) == 0);
            e = ($urandom_range(0, 7) != 0);
            d = $urandom_range(0, 1);
            s = 2'($urandom_range(0, 3));
            l = ($urandom_range(0, 7) == 0);
            lc = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       lv = 16'h0000;
                1:       lv = 16'h0001;
                2:       lv = 16'hFFFE;
                3:       lv = 16'hFFFF;
                default: lv = 16'($urandom);
            endcase
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            step(r, e, s, d, l, lc, lv, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
